// File: rtl/io_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : io_loader
// Purpose  : Host loader/monitor between the chip pads and the processor's
//            instruction and data memories. While run is low the host owns
//            both memories through a four-phase strobe/ack handshake. While
//            run is high the processor owns them.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset (async, active-low)
//   pad_start         async, 1 = processor runs (synchronised onto run)
//   pad_strobe        async host request, four-phase
//   pad_wr_rdb, pad_addr_memb, pad_instr_datab, pad_data_in
//                     operation select / write data, captured on accept
//   pad_data_out      registered read-back value
//   pad_ack           handshake acknowledge
//   pad_done          registered hlt & run
//   run               synchronised pad_start, to the processor
//   hlt               processor halted
//   uP_*              processor side memory requests / instruction feed
//   dataw_en, data_mem_addr, data_write_data, data_read_data
//                     data memory port (1-cycle synchronous read)
//   instrw_en, instr_mem_addr, instr_write_data, instr
//                     instruction memory port (1-cycle synchronous read)
// ============================================================================
module io_loader #(
   parameter int                DATA_W      = 16,
   parameter int                IADDR_W     = 13,
   parameter int                DADDR_W     = 8,
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] NOP_INSTR   = 16'h2004
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pad_start,
   input  logic               pad_strobe,
   input  logic               pad_wr_rdb,
   input  logic               pad_addr_memb,
   input  logic               pad_instr_datab,
   input  logic [DATA_W-1:0]  pad_data_in,
   output logic [DATA_W-1:0]  pad_data_out,
   output logic               pad_ack,
   output logic               pad_done,
   output logic               run,
   input  logic               hlt,
   input  logic [IADDR_W-1:0] uP_instr_mem_addr,
   output logic [DATA_W-1:0]  uP_instr,
   input  logic [DADDR_W-1:0] uP_data_mem_addr,
   input  logic [DATA_W-1:0]  uP_write_data,
   input  logic               uP_dataw_en,
   output logic               dataw_en,
   output logic [DADDR_W-1:0] data_mem_addr,
   output logic [DATA_W-1:0]  data_write_data,
   input  logic [DATA_W-1:0]  data_read_data,
   output logic               instrw_en,
   output logic [IADDR_W-1:0] instr_mem_addr,
   output logic [DATA_W-1:0]  instr_write_data,
   input  logic [DATA_W-1:0]  instr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WAIT = 2'd2,
      ACK  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] start_sync;
   logic [SYNC_STAGES-1:0] strobe_sync;
   logic                   stb_s;
   logic                   stb_s_d;
   logic                   stb_rise;

   logic                   op_wr;
   logic                   op_addr;
   logic                   op_instr;
   logic [DATA_W-1:0]      cap_data;

   logic [DADDR_W-1:0]     dload_addr;
   logic [IADDR_W-1:0]     iload_addr;
   logic [DATA_W-1:0]      daddr_ext;
   logic [DATA_W-1:0]      iaddr_ext;

   logic                   capture;
   logic                   in_exec;
   logic                   in_wait;
   logic                   ld_dwe;
   logic                   ld_iwe;
   logic                   d_load;
   logic                   i_load;
   logic                   d_inc;
   logic                   i_inc;
   logic                   addr_rd;
   logic                   mem_rd;

   // ---------------------------------------------------------------------
   // Pad synchronisers and strobe edge detect
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_sync  <= '0;
         strobe_sync <= '0;
         stb_s_d     <= 1'b0;
      end else begin
         start_sync  <= {start_sync[SYNC_STAGES-2:0], pad_start};
         strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], pad_strobe};
         stb_s_d     <= stb_s;
      end
   end

   assign run      = start_sync[SYNC_STAGES-1];
   assign stb_s    = strobe_sync[SYNC_STAGES-1];
   assign stb_rise = stb_s & ~stb_s_d;

   // ---------------------------------------------------------------------
   // Handshake FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (stb_rise) state_nxt = EXEC;
         EXEC:    state_nxt = WAIT;
         WAIT:    state_nxt = ACK;
         ACK:     if (!stb_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // The processor taking over aborts any transfer in flight.
      if (run) state_nxt = IDLE;
   end

   assign pad_ack = (state == ACK);

   // ---------------------------------------------------------------------
   // Operation decode. Every loader action is qualified with !run so that
   // a transfer aborted by run rising neither writes nor advances addresses.
   // ---------------------------------------------------------------------
   assign capture = (state == IDLE) & stb_rise & ~run;
   assign in_exec = (state == EXEC) & ~run;
   assign in_wait = (state == WAIT) & ~run;

   assign ld_dwe  = in_exec &  op_wr & ~op_addr & ~op_instr;
   assign ld_iwe  = in_exec &  op_wr & ~op_addr &  op_instr;
   assign d_load  = in_exec &  op_wr &  op_addr & ~op_instr;
   assign i_load  = in_exec &  op_wr &  op_addr &  op_instr;
   assign addr_rd = in_exec & ~op_wr &  op_addr;
   assign mem_rd  = in_wait & ~op_wr & ~op_addr;

   // Writes advance after EXEC, memory reads after the data is captured.
   assign d_inc   = ld_dwe | (mem_rd & ~op_instr);
   assign i_inc   = ld_iwe | (mem_rd &  op_instr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_wr    <= 1'b0;
         op_addr  <= 1'b0;
         op_instr <= 1'b0;
         cap_data <= '0;
      end else if (capture) begin
         op_wr    <= pad_wr_rdb;
         op_addr  <= pad_addr_memb;
         op_instr <= pad_instr_datab;
         cap_data <= pad_data_in;
      end
   end

   // ---------------------------------------------------------------------
   // Load address registers (hold their value across run periods)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dload_addr <= '0;
         iload_addr <= '0;
      end else begin
         if (d_load) begin
            dload_addr <= cap_data[DADDR_W-1:0];
         end else if (d_inc) begin
            dload_addr <= dload_addr + DADDR_W'(1);
         end
         if (i_load) begin
            iload_addr <= cap_data[IADDR_W-1:0];
         end else if (i_inc) begin
            iload_addr <= iload_addr + IADDR_W'(1);
         end
      end
   end

   always_comb begin
      daddr_ext                = '0;
      daddr_ext[DADDR_W-1:0]   = dload_addr;
      iaddr_ext                = '0;
      iaddr_ext[IADDR_W-1:0]   = iload_addr;
   end

   // ---------------------------------------------------------------------
   // Read-back register and halt flag
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pad_data_out <= '0;
         pad_done     <= 1'b0;
      end else begin
         pad_done <= hlt & run;
         if (addr_rd) begin
            pad_data_out <= op_instr ? iaddr_ext : daddr_ext;
         end else if (mem_rd) begin
            pad_data_out <= op_instr ? instr : data_read_data;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Memory port ownership
   // ---------------------------------------------------------------------
   always_comb begin
      dataw_en         = ld_dwe;
      data_mem_addr    = dload_addr;
      data_write_data  = cap_data;
      instrw_en        = ld_iwe;
      instr_mem_addr   = iload_addr;
      instr_write_data = cap_data;
      uP_instr         = NOP_INSTR;
      if (run) begin
         dataw_en        = uP_dataw_en;
         data_mem_addr   = uP_data_mem_addr;
         data_write_data = uP_write_data;
         instrw_en       = 1'b0;
         instr_mem_addr  = uP_instr_mem_addr;
         uP_instr        = instr;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_io_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_io_loader
// Purpose  : Self-checking bench for io_loader. Provides behavioural data and
//            instruction memories, a host handshake driver and a reference
//            model of the loader's addresses, memory contents and read-back.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_loader;

   localparam int DATA_W  = 16;
   localparam int IADDR_W = 13;
   localparam int DADDR_W = 8;
   localparam int SYNC    = 2;
   localparam int DSIZE   = 256;
   localparam int ISIZE   = 8192;

   logic               clk = 1'b0;
   logic               reset;
   logic               pad_start, pad_strobe;
   logic               pad_wr_rdb, pad_addr_memb, pad_instr_datab;
   logic [DATA_W-1:0]  pad_data_in;
   logic [DATA_W-1:0]  pad_data_out;
   logic               pad_ack, pad_done, run, hlt;
   logic [IADDR_W-1:0] uP_instr_mem_addr;
   logic [DATA_W-1:0]  uP_instr;
   logic [DADDR_W-1:0] uP_data_mem_addr;
   logic [DATA_W-1:0]  uP_write_data;
   logic               uP_dataw_en;
   logic               dataw_en, instrw_en;
   logic [DADDR_W-1:0] data_mem_addr;
   logic [DATA_W-1:0]  data_write_data;
   logic [DATA_W-1:0]  data_read_data = '0;
   logic [IADDR_W-1:0] instr_mem_addr;
   logic [DATA_W-1:0]  instr_write_data;
   logic [DATA_W-1:0]  instr = '0;

   always #5 clk = ~clk;

   io_loader #(
      .DATA_W(DATA_W), .IADDR_W(IADDR_W), .DADDR_W(DADDR_W),
      .SYNC_STAGES(SYNC), .NOP_INSTR(16'h2004)
   ) dut (
      .clk(clk), .reset(reset),
      .pad_start(pad_start), .pad_strobe(pad_strobe),
      .pad_wr_rdb(pad_wr_rdb), .pad_addr_memb(pad_addr_memb),
      .pad_instr_datab(pad_instr_datab), .pad_data_in(pad_data_in),
      .pad_data_out(pad_data_out), .pad_ack(pad_ack), .pad_done(pad_done),
      .run(run), .hlt(hlt),
      .uP_instr_mem_addr(uP_instr_mem_addr), .uP_instr(uP_instr),
      .uP_data_mem_addr(uP_data_mem_addr), .uP_write_data(uP_write_data),
      .uP_dataw_en(uP_dataw_en),
      .dataw_en(dataw_en), .data_mem_addr(data_mem_addr),
      .data_write_data(data_write_data), .data_read_data(data_read_data),
      .instrw_en(instrw_en), .instr_mem_addr(instr_mem_addr),
      .instr_write_data(instr_write_data), .instr(instr)
   );

   // Physical memories and write-pulse monitor
   logic [DATA_W-1:0]  dmem [0:DSIZE-1] = '{default: 16'h0};
   logic [DATA_W-1:0]  imem [0:ISIZE-1] = '{default: 16'h0};
   int                 dw_cnt = 0, iw_cnt = 0;
   logic [DADDR_W-1:0] dw_addr = '0;
   logic [IADDR_W-1:0] iw_addr = '0;
   logic [DATA_W-1:0]  dw_data = '0, iw_data = '0;

   always @(posedge clk) begin
      if (dataw_en) begin
         dmem[data_mem_addr] <= data_write_data;
         dw_cnt  <= dw_cnt + 1;
         dw_addr <= data_mem_addr;
         dw_data <= data_write_data;
      end
      if (instrw_en) begin
         imem[instr_mem_addr] <= instr_write_data;
         iw_cnt  <= iw_cnt + 1;
         iw_addr <= instr_mem_addr;
         iw_data <= instr_write_data;
      end
      data_read_data <= dmem[data_mem_addr];
      instr          <= imem[instr_mem_addr];
   end

   // Reference model state
   logic [DATA_W-1:0] dmodel [0:DSIZE-1] = '{default: 16'h0};
   logic [DATA_W-1:0] imodel [0:ISIZE-1] = '{default: 16'h0};
   int                m_dload = 0, m_iload = 0;
   logic [DATA_W-1:0] m_out = '0;

   int n_checks = 0, n_errors = 0;

   task automatic check_value(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One complete host transaction followed by a model update and checks.
   task automatic run_op(input logic [2:0] op, input logic [15:0] din,
                         input int hold, output logic [15:0] dout);
      int n, dw0, iw0;
      logic [15:0] exp;
      @(negedge clk);
      {pad_wr_rdb, pad_addr_memb, pad_instr_datab} = op;
      pad_data_in = din;
      dw0 = dw_cnt;
      iw0 = iw_cnt;
      pad_strobe = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!pad_ack && n < 20);
      check_value("ack_latency", n, SYNC + 3);
      dout = pad_data_out;
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         check_value("ack_held", {31'd0, pad_ack}, 1);
      end
      @(negedge clk);
      pad_data_in = 16'($urandom);
      {pad_wr_rdb, pad_addr_memb, pad_instr_datab} = 3'($urandom);
      pad_strobe = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (pad_ack && n < 20);
      check_value("ack_release", n, SYNC + 1);

      exp = m_out;
      case (op)
         3'd0: begin exp = dmodel[m_dload]; m_dload = (m_dload + 1) % DSIZE; end
         3'd1: begin exp = imodel[m_iload]; m_iload = (m_iload + 1) % ISIZE; end
         3'd2: exp = 16'(m_dload);
         3'd3: exp = 16'(m_iload);
         3'd4: begin
            check_value("dwr_addr", dw_addr, m_dload);
            check_value("dwr_data", dw_data, din);
            dmodel[m_dload] = din;
            m_dload = (m_dload + 1) % DSIZE;
         end
         3'd5: begin
            check_value("iwr_addr", iw_addr, m_iload);
            check_value("iwr_data", iw_data, din);
            imodel[m_iload] = din;
            m_iload = (m_iload + 1) % ISIZE;
         end
         3'd6: m_dload = int'(din) % DSIZE;
         default: m_iload = int'(din) % ISIZE;
      endcase
      check_value("dwr_pulses", dw_cnt - dw0, (op == 3'd4) ? 1 : 0);
      check_value("iwr_pulses", iw_cnt - iw0, (op == 3'd5) ? 1 : 0);
      check_value(op[2] ? "out_hold" : "read_data", dout, exp);
      m_out = exp;
   endtask

   task automatic check_idle_outputs(input string phase);
      check_value({phase, "_ack"},   {31'd0, pad_ack}, 0);
      check_value({phase, "_dout"},  pad_data_out, 0);
      check_value({phase, "_done"},  {31'd0, pad_done}, 0);
      check_value({phase, "_run"},   {31'd0, run}, 0);
      check_value({phase, "_dwe"},   {31'd0, dataw_en}, 0);
      check_value({phase, "_iwe"},   {31'd0, instrw_en}, 0);
      check_value({phase, "_uPi"},   uP_instr, 16'h2004);
      check_value({phase, "_daddr"}, data_mem_addr, 0);
      check_value({phase, "_iaddr"}, instr_mem_addr, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] d;
      logic [2:0]  op;
      logic [15:0] din;
      int          c0, k;
      logic        saw_ack;

      reset = 1'b0;
      pad_start = 1'b0; pad_strobe = 1'b0;
      pad_wr_rdb = 1'b0; pad_addr_memb = 1'b0; pad_instr_datab = 1'b0;
      pad_data_in = '0; hlt = 1'b0;
      uP_instr_mem_addr = '0; uP_data_mem_addr = '0;
      uP_write_data = '0; uP_dataw_en = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("rst");
      @(negedge clk);
      reset = 1'b1;

      // Instruction memory write / read-back with auto-increment
      run_op(3'd7, 16'h0010, 0, d);
      run_op(3'd5, 16'hA5A5, 0, d);
      run_op(3'd5, 16'h5A5A, 0, d);
      run_op(3'd7, 16'h0010, 0, d);
      run_op(3'd1, 16'h0000, 0, d);
      check_value("plan_rd0", d, 16'hA5A5);
      run_op(3'd1, 16'h0000, 0, d);
      check_value("plan_rd1", d, 16'h5A5A);
      run_op(3'd3, 16'h0000, 0, d);
      check_value("plan_iaddr", d, 16'h0012);

      // Data address wrap
      run_op(3'd6, 16'h00FF, 0, d);
      run_op(3'd4, 16'h1234, 0, d);
      check_value("plan_wr_ff", dw_addr, 8'hFF);
      run_op(3'd2, 16'h0000, 0, d);
      check_value("plan_wrap", d, 16'h0000);

      // Strobe held high: a single write pulse
      run_op(3'd4, 16'h7777, 20, d);

      // Processor start during EXEC of a data write
      @(negedge clk);
      {pad_wr_rdb, pad_addr_memb, pad_instr_datab} = 3'b100;
      pad_data_in = 16'hBEEF;
      uP_data_mem_addr = 8'h42;
      uP_instr_mem_addr = 13'h0010;
      uP_write_data = 16'hCAFE;
      c0 = dw_cnt;
      pad_strobe = 1'b1;
      @(posedge clk);
      @(negedge clk);
      pad_start = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_value("abort_run",   {31'd0, run}, 1);
      check_value("abort_dwe",   {31'd0, dataw_en}, 0);
      check_value("abort_daddr", data_mem_addr, 8'h42);
      check_value("abort_wdata", data_write_data, 16'hCAFE);
      check_value("abort_iaddr", instr_mem_addr, 13'h0010);
      saw_ack = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (pad_ack) saw_ack = 1'b1;
      end
      check_value("abort_no_ack", {31'd0, saw_ack}, 0);
      check_value("abort_no_wr", dw_cnt - c0, 0);
      check_value("abort_uPi", uP_instr, 16'hA5A5);
      @(negedge clk);
      pad_strobe = 1'b0;

      // Halt flag while running, then stop the processor
      check_value("done_pre", {31'd0, pad_done}, 0);
      hlt = 1'b1;
      @(posedge clk); #1;
      check_value("done_set", {31'd0, pad_done}, 1);
      @(negedge clk);
      pad_start = 1'b0;
      k = 0;
      do begin
         @(posedge clk); #1; k++;
      end while (run && k < 10);
      check_value("run_fall", {31'd0, run}, 0);
      check_value("stop_uPi", uP_instr, 16'h2004);
      check_value("done_lag", {31'd0, pad_done}, 1);
      @(posedge clk); #1;
      check_value("done_clr", {31'd0, pad_done}, 0);
      @(negedge clk);
      hlt = 1'b0;

      // Addresses survive the run period; the aborted write left no trace
      run_op(3'd2, 16'h0000, 0, d);
      run_op(3'd0, 16'h0000, 0, d);

      // Randomised traffic around both address wrap points
      for (int i = 0; i < 60; i++) begin
         op  = 3'($urandom_range(0, 7));
         din = 16'($urandom);
         if (op == 3'd6) din[7:0] = 8'($urandom_range(0, 7) + 252);
         if (op == 3'd7) din[12:0] = 13'($urandom_range(0, 7) + 8188);
         run_op(op, din, int'($urandom_range(0, 2)), d);
      end

      // Reset asserted during WAIT of a data read
      run_op(3'd6, 16'h1237, 0, d);
      run_op(3'd2, 16'h0000, 0, d);
      @(negedge clk);
      {pad_wr_rdb, pad_addr_memb, pad_instr_datab} = 3'b000;
      pad_strobe = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_idle_outputs("mid_rst");
      pad_strobe = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      m_dload = 0;
      m_iload = 0;
      m_out   = '0;
      run_op(3'd2, 16'h0000, 0, d);
      run_op(3'd3, 16'h0000, 0, d);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
